// File: rtl/frame_collision_detector.sv
// Frame-synchronous collision and border detector for the character, the arrow and N bubbles.
// Hits are collected in sticky flags during the frame, then published as one-cycle pulses after startOfFrame.
module frame_collision_detector #(
   parameter int N_BUBBLES = 4,
   parameter int COORD_W   = 11,
   parameter int FRAME_W   = 640,
   parameter int FRAME_H   = 480,
   parameter int IDX_W     = (N_BUBBLES > 1) ? $clog2(N_BUBBLES) : 1
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 startOfFrame,
   input  logic [COORD_W-1:0]   pixelX,
   input  logic [COORD_W-1:0]   pixelY,
   input  logic                 charDrawingRequest,
   input  logic                 arrowDrawingRequest,
   input  logic [N_BUBBLES-1:0] bubbleDrawingRequest,
   output logic                 charCrashLeft,
   output logic                 charCrashRight,
   output logic                 arrowHitTop,
   output logic                 bubbleHitChar,
   output logic                 arrowHitBubble,
   output logic [IDX_W-1:0]     arrowHitIdx,
   output logic [N_BUBBLES-1:0] bubbleHitFloor,
   output logic [N_BUBBLES-1:0] bubbleHitWall
);

   typedef enum logic {ACCUM = 1'b0, PUBLISH = 1'b1} state_t;

   // ahb doubles as the "index valid" bit: idx is only ever loaded together with it.
   typedef struct packed {
      logic                 crash_l;
      logic                 crash_r;
      logic                 top;
      logic                 bhc;
      logic                 ahb;
      logic [IDX_W-1:0]     idx;
      logic [N_BUBBLES-1:0] floor;
      logic [N_BUBBLES-1:0] wall;
   } flags_t;

   state_t state_q, state_d;
   flags_t sticky_q, sticky_d;
   flags_t out_q, out_d;
   flags_t base;

   logic             at_left, at_right, at_top, at_floor;
   logic             any_bubble;
   logic             arrow_bubble;
   logic [IDX_W-1:0] first_idx;
   logic             found;

   always_comb begin
      at_left      = (pixelX == '0);
      at_right     = (pixelX == COORD_W'(FRAME_W - 1));
      at_top       = (pixelY == '0);
      at_floor     = (pixelY == COORD_W'(FRAME_H - 1));
      any_bubble   = |bubbleDrawingRequest;
      arrow_bubble = arrowDrawingRequest && any_bubble;

      // Lowest-index bubble wins when several overlap the arrow in one cycle.
      first_idx = '0;
      found     = 1'b0;
      for (int i = 0; i < N_BUBBLES; i++) begin
         if (bubbleDrawingRequest[i] && !found) begin
            first_idx = IDX_W'(i);
            found     = 1'b1;
         end
      end

      // In the startOfFrame cycle the sticky set restarts from zero, but that cycle's events still count.
      base = startOfFrame ? '0 : sticky_q;

      sticky_d         = base;
      sticky_d.crash_l = base.crash_l | (charDrawingRequest && at_left);
      sticky_d.crash_r = base.crash_r | (charDrawingRequest && at_right);
      sticky_d.top     = base.top     | (arrowDrawingRequest && at_top);
      sticky_d.bhc     = base.bhc     | (charDrawingRequest && any_bubble);
      sticky_d.ahb     = base.ahb     | arrow_bubble;
      if (arrow_bubble && !base.ahb) begin
         sticky_d.idx = first_idx;
      end
      sticky_d.floor = base.floor | (at_floor ? bubbleDrawingRequest : '0);
      sticky_d.wall  = base.wall  | ((at_left || at_right) ? bubbleDrawingRequest : '0);

      if (startOfFrame) begin
         out_d = sticky_q;
      end else if (state_q == PUBLISH) begin
         out_d = '0;
      end else begin
         out_d = out_q;
      end

      state_d = startOfFrame ? PUBLISH : ACCUM;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= ACCUM;
         sticky_q <= '0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         sticky_q <= sticky_d;
         out_q    <= out_d;
      end
   end

   assign charCrashLeft  = out_q.crash_l;
   assign charCrashRight = out_q.crash_r;
   assign arrowHitTop    = out_q.top;
   assign bubbleHitChar  = out_q.bhc;
   assign arrowHitBubble = out_q.ahb;
   assign arrowHitIdx    = out_q.idx;
   assign bubbleHitFloor = out_q.floor;
   assign bubbleHitWall  = out_q.wall;

endmodule

// File: tb/tb_frame_collision_detector.sv
// Bench for frame_collision_detector: a per-frame event list is reduced to the expected publish
// vector whenever startOfFrame is driven; a negedge monitor pops and compares each publish.
module tb_frame_collision_detector;

   localparam int N  = 4;
   localparam int CW = 11;
   localparam int FW = 640;
   localparam int FH = 480;
   localparam int IW = 2;
   localparam int EW = 5 + IW + 2 * N;

   typedef struct {
      int           x;
      int           y;
      logic         c;
      logic         a;
      logic [N-1:0] b;
   } ev_t;

   logic          clk;
   logic          resetN;
   logic          startOfFrame;
   logic [CW-1:0] pixelX;
   logic [CW-1:0] pixelY;
   logic          charDrawingRequest;
   logic          arrowDrawingRequest;
   logic [N-1:0]  bubbleDrawingRequest;
   logic          charCrashLeft;
   logic          charCrashRight;
   logic          arrowHitTop;
   logic          bubbleHitChar;
   logic          arrowHitBubble;
   logic [IW-1:0] arrowHitIdx;
   logic [N-1:0]  bubbleHitFloor;
   logic [N-1:0]  bubbleHitWall;

   ev_t           frame_q[$];
   logic [EW-1:0] exp_q[$];
   int            total;
   int            bad;
   logic          sof_seen;
   logic          mon_on;

   frame_collision_detector #(
      .N_BUBBLES(N), .COORD_W(CW), .FRAME_W(FW), .FRAME_H(FH), .IDX_W(IW)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .pixelX(pixelX), .pixelY(pixelY),
      .charDrawingRequest(charDrawingRequest),
      .arrowDrawingRequest(arrowDrawingRequest),
      .bubbleDrawingRequest(bubbleDrawingRequest),
      .charCrashLeft(charCrashLeft), .charCrashRight(charCrashRight),
      .arrowHitTop(arrowHitTop), .bubbleHitChar(bubbleHitChar),
      .arrowHitBubble(arrowHitBubble), .arrowHitIdx(arrowHitIdx),
      .bubbleHitFloor(bubbleHitFloor), .bubbleHitWall(bubbleHitWall)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout total=%0d", total);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Reference: reduce the whole event list of a frame to the outputs it should produce.
   function automatic logic [EW-1:0] frame_result();
      logic          cl, cr, top, bhc, ahb;
      logic [IW-1:0] idx;
      logic [N-1:0]  fl, wl;
      ev_t           e;
      cl = 0; cr = 0; top = 0; bhc = 0; ahb = 0; idx = '0; fl = '0; wl = '0;
      foreach (frame_q[k]) begin
         e = frame_q[k];
         if (e.c && e.x == 0)      cl = 1;
         if (e.c && e.x == FW - 1) cr = 1;
         if (e.a && e.y == 0)      top = 1;
         if (e.c && e.b != 0)      bhc = 1;
         if (e.a && e.b != 0) begin
            if (!ahb) begin
               for (int i = N - 1; i >= 0; i--) begin
                  if (e.b[i]) idx = IW'(i);
               end
            end
            ahb = 1;
         end
         if (e.y == FH - 1)                 fl = fl | e.b;
         if (e.x == 0 || e.x == FW - 1)     wl = wl | e.b;
      end
      return {cl, cr, top, bhc, ahb, idx, fl, wl};
   endfunction

   // driver tasks
   task automatic cycle(input logic sof, input int x, input int y,
                        input logic c, input logic a, input logic [N-1:0] b);
      ev_t e;
      startOfFrame         = sof;
      pixelX               = CW'(x);
      pixelY               = CW'(y);
      charDrawingRequest   = c;
      arrowDrawingRequest  = a;
      bubbleDrawingRequest = b;
      e.x = x; e.y = y; e.c = c; e.a = a; e.b = b;
      if (sof) begin
         exp_q.push_back(frame_result());
         frame_q.delete();
      end
      frame_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, $urandom_range(1, FW - 2), $urandom_range(1, FH - 2), 1'b0, 1'b0, '0);
      end
   endtask

   task automatic do_reset();
      startOfFrame = 0; charDrawingRequest = 0; arrowDrawingRequest = 0; bubbleDrawingRequest = '0;
      #2;
      resetN = 1'b0;
      frame_q.delete();
      #1;
      total++;
      if ({charCrashLeft, charCrashRight, arrowHitTop, bubbleHitChar, arrowHitBubble,
           arrowHitIdx, bubbleHitFloor, bubbleHitWall} !== '0) begin
         bad++;
         $display("FAIL reset outputs got=%b exp=0", {charCrashLeft, charCrashRight, arrowHitTop,
                  bubbleHitChar, arrowHitBubble, arrowHitIdx, bubbleHitFloor, bubbleHitWall});
      end
      @(posedge clk);
      #1;
      resetN = 1'b1;
   endtask

   function automatic int pick_x();
      case ($urandom_range(0, 5))
         0: return 0;
         1: return FW - 1;
         2: return FW + $urandom_range(0, 100);
         default: return $urandom_range(0, FW - 1);
      endcase
   endfunction

   function automatic int pick_y();
      case ($urandom_range(0, 5))
         0: return 0;
         1: return FH - 1;
         2: return FH + $urandom_range(0, 100);
         default: return $urandom_range(0, FH - 1);
      endcase
   endfunction

   // scoreboard monitor
   always @(posedge clk or negedge resetN) begin
      if (!resetN) sof_seen <= 1'b0;
      else         sof_seen <= startOfFrame;
   end

   always @(negedge clk) begin
      logic [EW-1:0] got, exp;
      if (mon_on) begin
         got = {charCrashLeft, charCrashRight, arrowHitTop, bubbleHitChar, arrowHitBubble,
                arrowHitIdx, bubbleHitFloor, bubbleHitWall};
         total++;
         if (sof_seen) begin
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL publish_underflow got=%b exp=none", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  bad++;
                  $display("FAIL publish t=%0t got=%b exp=%b (cl cr top bhc ahb idx floor wall)",
                           $time, got, exp);
               end
            end
         end else if (got !== '0) begin
            bad++;
            $display("FAIL idle_zero t=%0t got=%b exp=0", $time, got);
         end
      end
   end

   // stimulus
   initial begin
      total = 0; bad = 0; mon_on = 0;
      resetN = 0; startOfFrame = 0; pixelX = '0; pixelY = '0;
      charDrawingRequest = 0; arrowDrawingRequest = 0; bubbleDrawingRequest = '0;
      repeat (3) @(posedge clk);
      #1;
      mon_on = 1;
      #4;
      total++;
      if ({charCrashLeft, charCrashRight, arrowHitTop, bubbleHitChar, arrowHitBubble,
           arrowHitIdx, bubbleHitFloor, bubbleHitWall} !== '0) begin
         bad++;
         $display("FAIL reset_state got=nonzero exp=0");
      end
      @(posedge clk);
      #1;
      resetN = 1;

      cycle(1, 5, 5, 0, 0, '0);
      idle(3);
      // char left column
      cycle(0, 0, 100, 1, 0, '0);
      idle(4);
      cycle(1, 5, 5, 0, 0, '0);
      idle(3);
      // arrow top, then two bubble overlaps; first one sets the index
      cycle(0, 50, 0, 0, 1, '0);
      cycle(0, 60, 10, 0, 1, 4'b0100);
      idle(2);
      cycle(0, 70, 20, 0, 1, 4'b0010);
      cycle(1, 5, 5, 0, 0, '0);
      idle(3);
      // same-cycle tie
      cycle(0, 80, 30, 0, 1, 4'b1010);
      cycle(1, 5, 5, 0, 0, '0);
      idle(3);
      // bubble borders
      cycle(0, 300, FH - 1, 0, 0, 4'b1000);
      cycle(0, FW - 1, 200, 0, 0, 4'b0001);
      cycle(1, 5, 5, 0, 0, '0);
      idle(3);
      // event inside the startOfFrame cycle belongs to the new frame
      cycle(1, 100, 100, 1, 0, 4'b0010);
      idle(3);
      cycle(1, 5, 5, 0, 0, '0);
      idle(3);
      // back-to-back startOfFrame
      cycle(1, 0, 0, 1, 1, 4'b0001);
      cycle(1, 5, 5, 0, 0, '0);
      idle(3);
      // reset mid-frame
      cycle(0, FW - 1, 5, 1, 0, '0);
      idle(2);
      do_reset();
      idle(3);
      cycle(1, 5, 5, 0, 0, '0);
      idle(3);

      // randomized frames
      for (int f = 0; f < 80; f++) begin
         int len;
         len = $urandom_range(0, 25);
         for (int k = 0; k < len; k++) begin
            cycle(1'b0, pick_x(), pick_y(), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 2) == 0), N'($urandom_range(0, 15) & $urandom_range(0, 15)));
         end
         cycle(1'b1, pick_x(), pick_y(), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 3) == 0), N'($urandom_range(0, 15) & $urandom_range(0, 15)));
         if (f == 40) begin
            idle(2);
            do_reset();
         end
      end
      idle(4);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
      mon_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
